tick_generator: RTL and testbench
=================================

# tick_generator

Parametrised multi-channel clock/tick generator driving the lab timing chain: stopwatch/counter logic, debouncers and the seven-segment scan mux. A shared prescaler produces base half-period events. NUM_CH cascaded channels each divide that rate by successive powers of RATIO, giving 50 % duty square waves plus single-cycle enable ticks. A runtime speed-up mode shortens the prescaler by SPEED, and a free-running scan counter drives the display digit select.

## Interface
- CLK_HZ, 100_000_000, input clock frequency in Hz
- BASE_HZ, 100, frequency of channel 0 (fastest channel)
- NUM_CH, 3, number of output channels (1..8)
- RATIO, 10, frequency ratio between adjacent channels (≥2)
- SPEED, 60, prescaler shortening factor while speedup=1 (≥1)
- SCAN_W, 2, scan select width
- SCAN_SHIFT, 15, scan counter low bits discarded
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- speedup  in  1  1 = fast mode
- hold  in  1  freeze prescaler and channels (see Configuration)
- clk_out  out  NUM_CH  square waves; bit k at BASE_HZ/RATIO^k (normal mode)
- tick  out  NUM_CH  one-cycle pulse on each rising edge of clk_out[k]
- scan  out  SCAN_W  display scan select

## Operation
- PRE_DIV = CLK_HZ/(2*BASE_HZ), integer division. Normal terminal TN = PRE_DIV-1. Fast terminal TF = PRE_DIV/SPEED-1. Elaboration must guarantee PRE_DIV/SPEED ≥ 1.
- Prescaler pcnt counts 0..T, where T = speedup ? TF : TN. A half-tick event is generated when pcnt ≥ T (≥, not ==). pcnt returns to 0 on that edge, otherwise increments.
- Channel k has a counter ccnt[k] of width max(1, clog2(RATIO^k)), counting half-ticks 0..RATIO^k-1. RATIO^k is computed by a constant function.
- On a half-tick with ccnt[k] = RATIO^k-1: ccnt[k]→0 and clk_out[k] toggles. Otherwise on a half-tick ccnt[k] increments. With no half-tick, the channel holds.
- Channel 0 therefore toggles on every half-tick.
- tick[k] is registered. It is 1 in exactly the cycle in which clk_out[k] first reads 1 after a 0→1 toggle, and 0 otherwise.
- The scan counter is (SCAN_W+SCAN_SHIFT) bits wide, free-running, and increments every clk with natural wrap. scan = its top SCAN_W bits. It ignores speedup and hold.
- Widths: pcnt is clog2(PRE_DIV) bits. All compares are unsigned at full width.

## Timing
- Reset (async, reset=0): pcnt, every ccnt, clk_out, tick and the scan counter all go to 0 immediately. They stay 0 while reset is low.
- Normal mode after reset release: the first half-tick is at rising edge PRE_DIV. clk_out[k] first rises at edge PRE_DIV·RATIO^k. The clk_out[k] period is 2·PRE_DIV·RATIO^k cycles.
- Latency: tick[k] and the clk_out[k] rise are driven by the same clock edge. Zero offset between them.
- speedup change mid-count takes effect on the next edge. If pcnt ≥ new T, a half-tick fires on that next edge and pcnt → 0. Channel counters are never reset by a mode change, and phase is preserved.
- Simultaneous wrap: all channels whose counters wrap on the same half-tick toggle on the same edge.
- Reset asserted mid-period abandons the partial period. There is no glitch beyond the async clear.

## Configuration
- TICKGEN_HOLD_EN defined: hold=1 freezes pcnt, ccnt and clk_out, and forces tick to 0. Release resumes from the frozen counts with no extra half-tick.
- TICKGEN_HOLD_EN undefined: the hold port exists but is ignored, and the logic is identical to hold tied 0.

## Test plan
Bench parameters: CLK_HZ=1000, BASE_HZ=100, NUM_CH=3, RATIO=10, SPEED=5, SCAN_W=2, SCAN_SHIFT=3. This gives PRE_DIV=5, TN=4, TF=0.
- Reset release, speedup=0 -> clk_out[0] rises at edge 5 with period 10. clk_out[1] rises at edge 50 with period 100. clk_out[2] rises at edge 500 with period 1000. Each tick[k] is one cycle wide, coincident with the rise.
- speedup=1 from reset -> half-tick every cycle. clk_out[0] toggles every edge, with tick[0] every 2 cycles. clk_out[1] has period 20.
- speedup 0→1 when pcnt=3 -> half-tick on the next edge, pcnt=0, and ccnt values retained.
- Hold (macro defined), asserted at edge 7 for 20 cycles -> pcnt, ccnt and clk_out are frozen and tick=0. Next clk_out[0] rise is at edge 35. Without the macro, the same stimulus gives a rise at edge 15.
- reset pulsed low mid-cycle at edge 237 -> all outputs 0 asynchronously. After release, the sequence restarts exactly as in test 1.
- scan -> increments every 8 cycles, sequence 0,1,2,3,0, wrapping at 32 cycles. Unaffected by speedup and hold.

Source files
------------

// File: rtl/tick_generator.sv
// Multi-channel tick generator: shared prescaler, cascaded divide-by-RATIO channels, display scan counter.
// Define TICKGEN_HOLD_EN to make the hold input freeze the prescaler and channels.
module tick_generator #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BASE_HZ    = 100,
    parameter int NUM_CH     = 3,
    parameter int RATIO      = 10,
    parameter int SPEED      = 60,
    parameter int SCAN_W     = 2,
    parameter int SCAN_SHIFT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              speedup,
    input  logic              hold,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [SCAN_W-1:0] scan
);

    localparam int PRE_DIV = CLK_HZ / (2 * BASE_HZ);
    localparam int PW      = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam int SCNT_W  = SCAN_W + SCAN_SHIFT;
    localparam logic [PW-1:0] T_N = PW'(PRE_DIV - 1);
    localparam logic [PW-1:0] T_F = PW'(PRE_DIV / SPEED - 1);

    generate
        if ((PRE_DIV / SPEED) < 1 || NUM_CH < 1 || NUM_CH > 8 || RATIO < 2) begin : g_bad_cfg
            $error("tick_generator: illegal parameter combination");
        end
    endgenerate

    function automatic int unsigned ratio_pow(input int k);
        int unsigned p;
        p = 1;
        for (int i = 0; i < k; i++) begin
            p = p * RATIO;
        end
        return p;
    endfunction

    logic          hold_act;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] t_sel;
    logic          at_term;
    logic          half;

`ifdef TICKGEN_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = hold & 1'b0;
`endif

    assign t_sel   = speedup ? T_F : T_N;
    assign at_term = (pcnt >= t_sel);
    assign half    = at_term & ~hold_act;

    // pcnt may sit above a freshly selected fast terminal; >= makes that fire at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
        end else if (!hold_act) begin
            if (at_term) pcnt <= '0;
            else         pcnt <= pcnt + PW'(1);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam int unsigned R  = ratio_pow(k);
        localparam int          CW = (R > 1) ? $clog2(R) : 1;
        localparam logic [CW-1:0] LAST = CW'(R - 1);

        logic [CW-1:0] ccnt;
        logic          co_r;
        logic          tk_r;
        logic          wrap;

        assign wrap = half & (ccnt == LAST);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                ccnt <= '0;
                co_r <= 1'b0;
                tk_r <= 1'b0;
            end else begin
                tk_r <= wrap & ~co_r;
                if (half) begin
                    if (ccnt == LAST) begin
                        ccnt <= '0;
                        co_r <= ~co_r;
                    end else begin
                        ccnt <= ccnt + CW'(1);
                    end
                end
            end
        end

        assign clk_out[k] = co_r;
        assign tick[k]    = tk_r;
    end

    logic [SCNT_W-1:0] scnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) scnt <= '0;
        else        scnt <= scnt + SCNT_W'(1);
    end

    assign scan = scnt[SCNT_W-1 -: SCAN_W];

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator: cycle scoreboard from a half-tick-count model plus edge-exact checks.
module tb_tick_generator;

    localparam int NCH = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           speedup = 1'b0;
    logic           hold = 1'b0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [1:0]     scan;

    tick_generator #(
        .CLK_HZ(1000), .BASE_HZ(100), .NUM_CH(NCH), .RATIO(10),
        .SPEED(5), .SCAN_W(2), .SCAN_SHIFT(3)
    ) dut (
        .clk(clk), .reset(reset), .speedup(speedup), .hold(hold),
        .clk_out(clk_out), .tick(tick), .scan(scan)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] c;
        logic [NCH-1:0] t;
        logic [1:0]     s;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;
    int   e      = 0;

    // Reference: channel k has toggled floor(h / 10^k) times after h half-ticks.
    int             m_pcnt;
    int             m_h;
    int             m_cyc;
    logic [NCH-1:0] m_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    endtask

    task automatic model_reset();
        m_pcnt = 0;
        m_h    = 0;
        m_cyc  = 0;
        m_prev = '0;
    endtask

    task automatic step();
        exp_t x;
        exp_t got;
        int   term;
        int   pw;
        logic hold_eff;
        logic half;
`ifdef TICKGEN_HOLD_EN
        hold_eff = hold;
`else
        hold_eff = 1'b0;
`endif
        term = speedup ? 0 : 4;
        half = (m_pcnt >= term) && !hold_eff;
        if (!hold_eff) m_pcnt = (m_pcnt >= term) ? 0 : m_pcnt + 1;
        if (half) m_h++;
        m_cyc++;
        pw = 1;
        for (int k = 0; k < NCH; k++) begin
            x.c[k] = ((m_h / pw) % 2) == 1;
            x.t[k] = half && x.c[k] && !m_prev[k];
            pw = pw * 10;
        end
        x.s    = 2'((m_cyc >> 3) & 3);
        m_prev = x.c;
        q.push_back(x);
        @(posedge clk);
        #1;
        e++;
        got = q.pop_front();
        chk("sb_clk_out", 32'(clk_out), 32'(got.c));
        chk("sb_tick", 32'(tick), 32'(got.t));
        chk("sb_scan", 32'(scan), 32'(got.s));
    endtask

    task automatic run_to(input int target);
        while (e < target) step();
    endtask

    task automatic do_reset();
        #3;
        reset = 1'b0;
        #1;
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_scan", 32'(scan), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_low", 32'({clk_out, tick, scan}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        e = 0;
    endtask

    initial begin
        model_reset();
        speedup = 1'b0;
        hold    = 1'b0;
        do_reset();

        // Normal mode, then reset pulse mid-period at edge 237.
        run_to(4);   chk("n_clk0_e4", 32'(clk_out[0]), 32'd0);
        run_to(5);   chk("n_clk0_e5", 32'(clk_out[0]), 32'd1);
                     chk("n_tick0_e5", 32'(tick[0]), 32'd1);
        run_to(6);   chk("n_tick0_e6", 32'(tick[0]), 32'd0);
        run_to(8);   chk("scan_e8", 32'(scan), 32'd1);
        run_to(16);  chk("scan_e16", 32'(scan), 32'd2);
        run_to(24);  chk("scan_e24", 32'(scan), 32'd3);
        run_to(32);  chk("scan_e32", 32'(scan), 32'd0);
        run_to(49);  chk("n_clk1_e49", 32'(clk_out[1]), 32'd0);
        run_to(50);  chk("n_clk1_e50", 32'(clk_out[1]), 32'd1);
                     chk("n_tick1_e50", 32'(tick[1]), 32'd1);
        run_to(51);  chk("n_tick1_e51", 32'(tick[1]), 32'd0);
        run_to(237);
        do_reset();

        // Restart after reset pulse must match a fresh start.
        run_to(5);    chk("r_clk0_e5", 32'(clk_out[0]), 32'd1);
        run_to(15);   chk("r_clk0_e15", 32'(clk_out[0]), 32'd1);
        run_to(150);  chk("r_clk1_e150", 32'(clk_out[1]), 32'd1);
        run_to(499);  chk("r_clk2_e499", 32'(clk_out[2]), 32'd0);
        run_to(500);  chk("r_clk2_e500", 32'(clk_out[2]), 32'd1);
                      chk("r_tick2_e500", 32'(tick[2]), 32'd1);
        run_to(1000); chk("r_clk2_e1000", 32'(clk_out[2]), 32'd0);
        run_to(1500); chk("r_clk2_e1500", 32'(clk_out[2]), 32'd1);
                      chk("r_tick2_e1500", 32'(tick[2]), 32'd1);

        // Fast mode from reset: a half-tick every cycle.
        speedup = 1'b1;
        do_reset();
        run_to(1);  chk("f_clk0_e1", 32'(clk_out[0]), 32'd1);
                    chk("f_tick0_e1", 32'(tick[0]), 32'd1);
        run_to(2);  chk("f_clk0_e2", 32'(clk_out[0]), 32'd0);
        run_to(3);  chk("f_tick0_e3", 32'(tick[0]), 32'd1);
        run_to(10); chk("f_clk1_e10", 32'(clk_out[1]), 32'd1);
        run_to(20); chk("f_clk1_e20", 32'(clk_out[1]), 32'd0);
        run_to(30); chk("f_clk1_e30", 32'(clk_out[1]), 32'd1);
                    chk("f_tick1_e30", 32'(tick[1]), 32'd1);

        // Switch to fast mode while pcnt = 3.
        speedup = 1'b0;
        do_reset();
        run_to(3);
        speedup = 1'b1;
        run_to(4);  chk("sw_clk0_e4", 32'(clk_out[0]), 32'd1);
                    chk("sw_tick0_e4", 32'(tick[0]), 32'd1);
        run_to(40);

        // Hold asserted after edge 7 for 20 cycles.
        speedup = 1'b0;
        do_reset();
        run_to(7);
        hold = 1'b1;
        run_to(27);
        hold = 1'b0;
`ifdef TICKGEN_HOLD_EN
        run_to(34); chk("h_clk0_e34", 32'(clk_out[0]), 32'd0);
        run_to(35); chk("h_clk0_e35", 32'(clk_out[0]), 32'd1);
                    chk("h_tick0_e35", 32'(tick[0]), 32'd1);
`else
        chk("h_clk0_e27", 32'(clk_out[0]), 32'd1);
        run_to(35); chk("h_clk0_e35", 32'(clk_out[0]), 32'd1);
`endif
        run_to(60);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
